// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage.
package id_stage_pkg;

   localparam int XW = 32;

   localparam logic [XW-1:0] ZeroWord = '0;
   localparam logic [4:0]    ZeroReg  = '0;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   typedef enum logic [1:0] {
      BR_NONE,
      BR_COND,
      BR_JAL,
      BR_JALR
   } br_kind_t;

   typedef struct packed {
      logic [XW-1:0] op1;
      logic [XW-1:0] op2;
      logic [XW-1:0] imm;
      logic          we;
      logic          ill;
      logic          use1;
      logic          use2;
      br_kind_t      kind;
   } id_dec_t;

endpackage

// File: rtl/id_branch_unit.sv
// Combinational branch/jump resolution: condition and redirect target.
module id_branch_unit
   import id_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  br_kind_t         kind,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   output logic             taken,
   output logic [XLEN-1:0]  target
);

   localparam logic [XLEN-1:0] LsbClr = {{(XLEN-1){1'b1}}, 1'b0};

   logic cond;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = (rs1 == rs2);
         F3_BNE:  cond = (rs1 != rs2);
         F3_BLT:  cond = ($signed(rs1) < $signed(rs2));
         F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
         F3_BLTU: cond = (rs1 < rs2);
         F3_BGEU: cond = (rs1 >= rs2);
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (kind)
         BR_COND: taken = cond;
         BR_JAL:  taken = 1'b1;
         BR_JALR: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   assign target = (kind == BR_JALR) ? ((rs1 + imm) & LsbClr)
                                     : (pc + imm);

endmodule

// File: rtl/id_stage.sv
// One-entry registered decode stage with load-use stall and
// writeback forwarding; branches and jumps resolve at accept.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int M_EXT  = 1,
   parameter int FWD_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      inst_i,
   input  logic [XLEN-1:0]  inst_addr_i,
   output logic [4:0]       reg1_raddr_o,
   output logic [4:0]       reg2_raddr_o,
   input  logic [XLEN-1:0]  reg1_rdata_i,
   input  logic [XLEN-1:0]  reg2_rdata_i,
   input  logic             fwd_we_i,
   input  logic [4:0]       fwd_waddr_i,
   input  logic [XLEN-1:0]  fwd_wdata_i,
   input  logic             ex_load_i,
   input  logic [4:0]       ex_waddr_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      inst_o,
   output logic [XLEN-1:0]  inst_addr_o,
   output logic [XLEN-1:0]  op1_o,
   output logic [XLEN-1:0]  op2_o,
   output logic [XLEN-1:0]  reg1_rdata_o,
   output logic [XLEN-1:0]  reg2_rdata_o,
   output logic             reg_we_o,
   output logic [4:0]       reg_waddr_o,
   output logic             jump_flag_o,
   output logic [XLEN-1:0]  jump_addr_o,
   output logic             illegal_o
);

   logic [6:0]       opcode;
   logic [6:0]       f7;
   logic [2:0]       f3;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [4:0]       rd;
   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;
   logic [XLEN-1:0]  imm_i;
   logic [XLEN-1:0]  imm_s;
   logic [XLEN-1:0]  imm_b;
   logic [XLEN-1:0]  imm_u;
   logic [XLEN-1:0]  imm_j;
   logic [XLEN-1:0]  target;
   logic [4:0]       waddr;
   logic             taken;
   logic             hazard;
   logic             accept;
   logic             consume;
   id_dec_t          dec;

   assign opcode = inst_i[6:0];
   assign rd     = inst_i[11:7];
   assign f3     = inst_i[14:12];
   assign rs1    = inst_i[19:15];
   assign rs2    = inst_i[24:20];
   assign f7     = inst_i[31:25];

   assign reg1_raddr_o = rs1;
   assign reg2_raddr_o = rs2;

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                   inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'b0};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                   inst_i[20], inst_i[30:21], 1'b0};

   // x0 never forwards; a same-cycle writeback beats the regfile
   assign rs1_val =
      (rs1 == ZeroReg) ? ZeroWord :
      (FWD_EN != 0 && fwd_we_i && fwd_waddr_i == rs1) ? fwd_wdata_i :
      reg1_rdata_i;
   assign rs2_val =
      (rs2 == ZeroReg) ? ZeroWord :
      (FWD_EN != 0 && fwd_we_i && fwd_waddr_i == rs2) ? fwd_wdata_i :
      reg2_rdata_i;

   always_comb begin
      dec = '{op1: ZeroWord, op2: ZeroWord, imm: ZeroWord,
              we: 1'b0, ill: 1'b0, use1: 1'b0, use2: 1'b0,
              kind: BR_NONE};
      case (opcode)
         OP_IMM: begin
            dec.use1 = 1'b1;
            dec.op1  = rs1_val;
            dec.op2  = imm_i;
            dec.we   = 1'b1;
            dec.ill  = (f3 == F3_SLL && f7 != F7_BASE) ||
                       (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
         end
         OP_REG: begin
            dec.use1 = 1'b1;
            dec.use2 = 1'b1;
            dec.op1  = rs1_val;
            dec.op2  = rs2_val;
            dec.we   = 1'b1;
            dec.ill  = !((f7 == F7_BASE) ||
                         (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) ||
                         (f7 == F7_MUL && M_EXT != 0));
         end
         OP_LOAD: begin
            dec.use1 = 1'b1;
            dec.op1  = rs1_val;
            dec.op2  = imm_i;
            dec.we   = 1'b1;
            dec.ill  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OP_STORE: begin
            dec.use1 = 1'b1;
            dec.use2 = 1'b1;
            dec.op1  = rs1_val;
            dec.op2  = imm_s;
            dec.ill  = (f3 > 3'b010);
         end
         OP_BRANCH: begin
            dec.use1 = 1'b1;
            dec.use2 = 1'b1;
            dec.op1  = rs1_val;
            dec.op2  = rs2_val;
            dec.imm  = imm_b;
            dec.kind = BR_COND;
            dec.ill  = (f3[2:1] == 2'b01);
         end
         OP_JAL: begin
            dec.op1  = inst_addr_i;
            dec.op2  = 32'd4;
            dec.imm  = imm_j;
            dec.we   = 1'b1;
            dec.kind = BR_JAL;
         end
         OP_JALR: begin
            dec.use1 = 1'b1;
            dec.op1  = inst_addr_i;
            dec.op2  = 32'd4;
            dec.imm  = imm_i;
            dec.we   = 1'b1;
            dec.kind = BR_JALR;
            dec.ill  = (f3 != 3'b000);
         end
         OP_LUI: begin
            dec.op2 = imm_u;
            dec.we  = 1'b1;
         end
         OP_AUIPC: begin
            dec.op1 = inst_addr_i;
            dec.op2 = imm_u;
            dec.we  = 1'b1;
         end
         OP_FENCE: dec.ill = (f3 > 3'b001);
         default:  dec.ill = 1'b1;
      endcase
      if (dec.ill) begin
         dec.we   = 1'b0;
         dec.kind = BR_NONE;
      end
   end

   assign waddr = dec.we ? rd : ZeroReg;

   assign hazard = ex_load_i && (ex_waddr_i != ZeroReg) &&
                   ((dec.use1 && ex_waddr_i == rs1) ||
                    (dec.use2 && ex_waddr_i == rs2));

   assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
   assign accept     = in_valid_i && in_ready_o;
   assign consume    = out_valid_o && out_ready_i;

   id_branch_unit #(.XLEN(XLEN)) u_branch (
      .kind   (dec.kind),
      .rs1    (rs1_val),
      .rs2    (rs2_val),
      .funct3 (f3),
      .pc     (inst_addr_i),
      .imm    (dec.imm),
      .taken  (taken),
      .target (target)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_o  <= 1'b0;
         inst_o       <= '0;
         inst_addr_o  <= '0;
         op1_o        <= '0;
         op2_o        <= '0;
         reg1_rdata_o <= '0;
         reg2_rdata_o <= '0;
         reg_we_o     <= 1'b0;
         reg_waddr_o  <= ZeroReg;
         jump_flag_o  <= 1'b0;
         jump_addr_o  <= '0;
         illegal_o    <= 1'b0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
         illegal_o   <= 1'b0;
         jump_flag_o <= 1'b0;
         jump_addr_o <= '0;
      end else if (accept) begin
         out_valid_o  <= 1'b1;
         inst_o       <= inst_i;
         inst_addr_o  <= inst_addr_i;
         op1_o        <= dec.op1;
         op2_o        <= dec.op2;
         reg1_rdata_o <= rs1_val;
         reg2_rdata_o <= rs2_val;
         reg_we_o     <= dec.we;
         reg_waddr_o  <= waddr;
         illegal_o    <= dec.ill;
         jump_flag_o  <= taken;
         jump_addr_o  <= taken ? target : '0;
      end else begin
         // redirect is a single pulse even while the entry stalls
         jump_flag_o <= 1'b0;
         jump_addr_o <= '0;
         if (consume) begin
            out_valid_o <= 1'b0;
            illegal_o   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table through a scoreboard,
// then directed stall, hazard, flush and reset sequences.
module tb_id_stage;

   localparam logic [6:0] T_IMM   = 7'b0010011;
   localparam logic [6:0] T_REG   = 7'b0110011;
   localparam logic [6:0] T_LOAD  = 7'b0000011;
   localparam logic [6:0] T_JALR  = 7'b1100111;
   localparam logic [6:0] T_LUI   = 7'b0110111;
   localparam logic [6:0] T_AUIPC = 7'b0010111;
   localparam logic [6:0] T_FENCE = 7'b0001111;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        fwe;
      logic [4:0]  fwa;
      logic [31:0] fwd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        we;
      logic [4:0]  wa;
      logic        ill;
      logic        jf;
      logic [31:0] ja;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, fwd_we, ex_load, flush;
   logic        out_ready, out_valid, reg_we, jump_flag, illegal;
   logic [31:0] inst, inst_addr, rd1_in, rd2_in, fwd_wdata;
   logic [31:0] inst_o, inst_addr_o, op1, op2, rd1_o, rd2_o, jump_addr;
   logic [4:0]  ra1, ra2, fwd_waddr, ex_waddr, reg_waddr;

   logic        m_in_ready, m_out_valid, m_we, m_jf, m_ill;
   logic [31:0] m_inst, m_pc, m_op1, m_op2, m_rd1, m_rd2, m_ja;
   logic [4:0]  m_ra1, m_ra2, m_wa;

   int npass = 0;
   int ntot  = 0;
   vec_t tab[$];
   vec_t sb[$];
   vec_t e;

   id_stage #(.XLEN(32), .M_EXT(0), .FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .inst_i(inst), .inst_addr_i(inst_addr),
      .reg1_raddr_o(ra1), .reg2_raddr_o(ra2),
      .reg1_rdata_i(rd1_in), .reg2_rdata_i(rd2_in),
      .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
      .ex_load_i(ex_load), .ex_waddr_i(ex_waddr), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1), .op2_o(op2),
      .reg1_rdata_o(rd1_o), .reg2_rdata_o(rd2_o),
      .reg_we_o(reg_we), .reg_waddr_o(reg_waddr),
      .jump_flag_o(jump_flag), .jump_addr_o(jump_addr),
      .illegal_o(illegal)
   );

   id_stage #(.XLEN(32), .M_EXT(1), .FWD_EN(1)) dut_m (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(m_in_ready),
      .inst_i(inst), .inst_addr_i(inst_addr),
      .reg1_raddr_o(m_ra1), .reg2_raddr_o(m_ra2),
      .reg1_rdata_i(rd1_in), .reg2_rdata_i(rd2_in),
      .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
      .ex_load_i(ex_load), .ex_waddr_i(ex_waddr), .flush_i(flush),
      .out_valid_o(m_out_valid), .out_ready_i(out_ready),
      .inst_o(m_inst), .inst_addr_o(m_pc), .op1_o(m_op1), .op2_o(m_op2),
      .reg1_rdata_o(m_rd1), .reg2_rdata_o(m_rd2),
      .reg_we_o(m_we), .reg_waddr_o(m_wa),
      .jump_flag_o(m_jf), .jump_addr_o(m_ja),
      .illegal_o(m_ill)
   );

   function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd,
                                         logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
                                         logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2,
                                         logic [4:0] rs1, logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2,
                                         logic [4:0] rs1, logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
              7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_u(logic [31:0] imm, logic [4:0] rd,
                                         logic [6:0] op);
      return {imm[19:0], rd, op};
   endfunction

   function automatic vec_t mk(logic [31:0] i, logic [31:0] pc,
                               logic [31:0] r1, logic [31:0] r2,
                               logic [31:0] o1, logic [31:0] o2,
                               logic we, logic [4:0] wa, logic ill,
                               logic jf, logic [31:0] ja);
      vec_t v;
      v.inst = i;  v.pc = pc;  v.r1 = r1;  v.r2 = r2;
      v.fwe = 1'b0;  v.fwa = 5'd0;  v.fwd = 32'd0;
      v.op1 = o1;  v.op2 = o2;  v.we = we;  v.wa = wa;
      v.ill = ill;  v.jf = jf;  v.ja = ja;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t f;
      rst = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;  flush = 1'b0;
      ex_load = 1'b0;  ex_waddr = 5'd0;  fwd_we = 1'b0;
      fwd_waddr = 5'd0;  fwd_wdata = 32'd0;
      inst = enc_i(32'd5, 5'd0, 3'b000, 5'd1, T_IMM);
      inst_addr = 32'h10;  rd1_in = 32'h1;  rd2_in = 32'h2;

      // reset holds everything low even with a valid offer and clocks
      in_valid = 1'b1;
      tick();
      tick();
      chk("rst_valid", 0, out_valid, 0);
      chk("rst_we", 0, reg_we, 0);
      chk("rst_jf", 0, jump_flag, 0);
      chk("rst_ill", 0, illegal, 0);
      chk("rst_op2", 0, op2, 0);
      chk("rst_waddr", 0, reg_waddr, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();

      tab.push_back(mk(enc_i(32'd5, 5'd0, 3'b000, 5'd1, T_IMM), 32'h0,
                       32'h55, 32'h0, 32'h0, 32'd5, 1, 5'd1, 0, 0, 32'h0));
      tab.push_back(mk(enc_i(32'hFFFFFFFF, 5'd2, 3'b000, 5'd3, T_IMM), 32'h4,
                       32'd10, 32'h0, 32'd10, 32'hFFFFFFFF, 1, 5'd3, 0, 0, 0));
      tab.push_back(mk(enc_r(7'h00, 5'd5, 5'd3, 3'b000, 5'd4, T_REG), 32'h8,
                       32'd100, 32'd200, 32'd100, 32'd200, 1, 5'd4, 0, 0, 0));
      tab.push_back(mk(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd6, T_REG), 32'hC,
                       32'd7, 32'd3, 32'd7, 32'd3, 1, 5'd6, 0, 0, 0));
      tab.push_back(mk(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd7, T_REG), 32'h10,
                       32'd7, 32'd3, 32'd0, 32'd0, 0, 5'd0, 1, 0, 0));
      tab.push_back(mk(enc_i(32'hFFFFFFFC, 5'd9, 3'b010, 5'd8, T_LOAD), 32'h14,
                       32'h1000, 32'h0, 32'h1000, 32'hFFFFFFFC, 1, 5'd8, 0, 0, 0));
      tab.push_back(mk(enc_s(32'd8, 5'd5, 5'd6, 3'b010), 32'h18,
                       32'h200, 32'h77, 32'h200, 32'd8, 0, 5'd0, 0, 0, 0));
      tab.push_back(mk(enc_b(32'h20, 5'd2, 5'd1, 3'b000), 32'h100,
                       32'd7, 32'd7, 32'd7, 32'd7, 0, 5'd0, 0, 1, 32'h120));
      tab.push_back(mk(enc_b(32'h20, 5'd2, 5'd1, 3'b001), 32'h100,
                       32'd7, 32'd7, 32'd7, 32'd7, 0, 5'd0, 0, 0, 32'h0));
      tab.push_back(mk(enc_b(32'hFFFFFFF8, 5'd2, 5'd1, 3'b100), 32'h200,
                       32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 0, 5'd0, 0,
                       1, 32'h1F8));
      tab.push_back(mk(enc_b(32'hFFFFFFF8, 5'd2, 5'd1, 3'b110), 32'h200,
                       32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 0, 5'd0, 0,
                       0, 32'h0));
      tab.push_back(mk(enc_b(32'hFFFFFFF8, 5'd2, 5'd1, 3'b111), 32'h200,
                       32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 0, 5'd0, 0,
                       1, 32'h1F8));
      tab.push_back(mk(enc_b(32'hFFFFFFF8, 5'd2, 5'd1, 3'b101), 32'h200,
                       32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 0, 5'd0, 0,
                       0, 32'h0));
      tab.push_back(mk(enc_j(32'h800, 5'd1), 32'h400, 32'h0, 32'h0,
                       32'h400, 32'd4, 1, 5'd1, 0, 1, 32'hC00));
      tab.push_back(mk(enc_i(32'd3, 5'd6, 3'b000, 5'd5, T_JALR), 32'h40,
                       32'h1000, 32'h0, 32'h40, 32'd4, 1, 5'd5, 0, 1, 32'h1002));
      tab.push_back(mk(enc_u(32'h12345, 5'd10, T_LUI), 32'h44, 32'h9, 32'h9,
                       32'h0, 32'h12345000, 1, 5'd10, 0, 0, 0));
      tab.push_back(mk(enc_u(32'h1, 5'd11, T_AUIPC), 32'h80, 32'h0, 32'h0,
                       32'h80, 32'h1000, 1, 5'd11, 0, 0, 0));
      tab.push_back(mk(enc_i(32'd0, 5'd0, 3'b000, 5'd0, T_FENCE), 32'h84,
                       32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 0, 0));
      tab.push_back(mk(32'hFFFFFFFF, 32'h88, 32'h0, 32'h0,
                       32'h0, 32'h0, 0, 5'd0, 1, 0, 0));
      tab.push_back(mk(enc_r(7'h20, 5'd3, 5'd1, 3'b001, 5'd4, T_IMM), 32'h8C,
                       32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 1, 0, 0));
      tab.push_back(mk(enc_b(32'h20, 5'd2, 5'd1, 3'b010), 32'h90,
                       32'd7, 32'd7, 32'h0, 32'h0, 0, 5'd0, 1, 0, 0));
      tab.push_back(mk(enc_r(7'h20, 5'd4, 5'd1, 3'b101, 5'd2, T_IMM), 32'h94,
                       32'h80000000, 32'h0, 32'h80000000, 32'h404, 1, 5'd2,
                       0, 0, 0));
      f = mk(enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd3, T_REG), 32'h98,
             32'h0, 32'h0, 32'hDEAD, 32'hDEAD, 1, 5'd3, 0, 0, 0);
      f.fwe = 1'b1;  f.fwa = 5'd2;  f.fwd = 32'hDEAD;
      tab.push_back(f);
      f = mk(enc_i(32'd1, 5'd0, 3'b000, 5'd1, T_IMM), 32'h9C,
             32'h99, 32'h0, 32'h0, 32'd1, 1, 5'd1, 0, 0, 0);
      f.fwe = 1'b1;  f.fwa = 5'd0;  f.fwd = 32'hBEEF;
      tab.push_back(f);

      foreach (tab[i]) begin
         inst = tab[i].inst;  inst_addr = tab[i].pc;
         rd1_in = tab[i].r1;  rd2_in = tab[i].r2;
         fwd_we = tab[i].fwe;  fwd_waddr = tab[i].fwa;
         fwd_wdata = tab[i].fwd;
         in_valid = 1'b1;
         @(negedge clk);
         chk("ready", i, in_ready, 1);
         if (in_ready) sb.push_back(tab[i]);
         tick();
         in_valid = 1'b0;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("valid", i, out_valid, 1);
            chk("inst", i, inst_o, e.inst);
            chk("pc", i, inst_addr_o, e.pc);
            chk("we", i, reg_we, e.we);
            chk("waddr", i, reg_waddr, e.wa);
            chk("illegal", i, illegal, e.ill);
            chk("jflag", i, jump_flag, e.jf);
            chk("jaddr", i, jump_addr, e.ja);
            if (!e.ill) begin
               chk("op1", i, op1, e.op1);
               chk("op2", i, op2, e.op2);
            end
         end else begin
            chk("no_output", i, 0, 1);
         end
      end
      fwd_we = 1'b0;

      // the M-enabled instance decodes mul as a writing R-type
      inst = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd7, T_REG);
      rd1_in = 32'd6;  rd2_in = 32'd9;  in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("m_ill", 0, m_ill, 0);
      chk("m_we", 0, m_we, 1);
      chk("m_waddr", 0, m_wa, 7);
      chk("m_op2", 0, m_op2, 9);
      chk("nom_ill", 0, illegal, 1);
      tick();

      // load-use hazard probes
      ex_load = 1'b1;  ex_waddr = 5'd3;
      inst = enc_r(7'h00, 5'd5, 5'd3, 3'b000, 5'd4, T_REG);
      @(negedge clk);
      chk("hz_rs1", 0, in_ready, 0);
      ex_waddr = 5'd5;
      #1 chk("hz_rs2", 0, in_ready, 0);
      ex_waddr = 5'd3;
      inst = enc_u(32'h18, 5'd3, T_LUI);
      #1 chk("hz_lui", 0, in_ready, 1);
      ex_waddr = 5'd0;
      inst = enc_i(32'd5, 5'd0, 3'b000, 5'd1, T_IMM);
      #1 chk("hz_x0", 0, in_ready, 1);
      tick();
      ex_waddr = 5'd3;
      inst = enc_r(7'h00, 5'd5, 5'd3, 3'b000, 5'd4, T_REG);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hz_stall", k, in_ready, 0);
         tick();
         chk("hz_noval", k, out_valid, 0);
      end
      ex_load = 1'b0;
      @(negedge clk);
      chk("hz_go", 0, in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("hz_val", 0, out_valid, 1);
      chk("hz_wa", 0, reg_waddr, 4);
      tick();

      // taken branch held under back-pressure
      out_ready = 1'b0;
      inst = enc_b(32'h20, 5'd2, 5'd1, 3'b000);
      inst_addr = 32'h100;  rd1_in = 32'd7;  rd2_in = 32'd7;
      in_valid = 1'b1;
      @(negedge clk);
      chk("st_acc", 0, in_ready, 1);
      tick();
      chk("st_jf", 0, jump_flag, 1);
      chk("st_ja", 0, jump_addr, 32'h120);
      inst = enc_i(32'd5, 5'd0, 3'b000, 5'd1, T_IMM);
      inst_addr = 32'h104;  rd1_in = 32'h3;  rd2_in = 32'h3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("st_rdy", k, in_ready, 0);
         tick();
         chk("st_valid", k, out_valid, 1);
         chk("st_jf0", k, jump_flag, 0);
         chk("st_ja0", k, jump_addr, 0);
         chk("st_hold", k, inst_o, enc_b(32'h20, 5'd2, 5'd1, 3'b000));
         chk("st_op1", k, op1, 7);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("st_swap_rdy", 0, in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("st_swap_v", 0, out_valid, 1);
      chk("st_swap_op2", 0, op2, 5);
      chk("st_swap_wa", 0, reg_waddr, 1);
      chk("st_swap_we", 0, reg_we, 1);
      tick();
      chk("st_drain", 0, out_valid, 0);

      // flush while an illegal entry stalls
      out_ready = 1'b0;
      inst = 32'hFFFFFFFF;  in_valid = 1'b1;
      tick();
      chk("fl_ill", 0, illegal, 1);
      tick();
      chk("fl_hold", 0, illegal, 1);
      flush = 1'b1;
      inst = enc_i(32'd5, 5'd0, 3'b000, 5'd1, T_IMM);
      @(negedge clk);
      chk("fl_rdy", 0, in_ready, 0);
      tick();
      chk("fl_valid", 0, out_valid, 0);
      chk("fl_ill0", 0, illegal, 0);
      out_ready = 1'b1;
      inst = enc_j(32'h800, 5'd1);
      @(negedge clk);
      chk("fl_rdy2", 0, in_ready, 0);
      tick();
      chk("fl_valid2", 0, out_valid, 0);
      chk("fl_jf", 0, jump_flag, 0);
      flush = 1'b0;
      in_valid = 1'b0;
      tick();

      // asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      inst = enc_i(32'd5, 5'd0, 3'b000, 5'd1, T_IMM);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ar_valid", 0, out_valid, 1);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("ar_valid0", 0, out_valid, 0);
      chk("ar_we", 0, reg_we, 0);
      chk("ar_op2", 0, op2, 0);
      chk("ar_inst", 0, inst_o, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("ar_after", 0, out_valid, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
